bram_a_stream_ctrl: RTL

//   Upstream controller for the 32x32 single-port block RAM "memory A" (port-A wrapper).
//   On a start pulse it fills DEPTH words from a valid/ready input stream into the RAM,

---
 rtl/bram_a_pkg.sv | 13 +
 rtl/bram_a_out_skid.sv | 57 +++++
 rtl/bram_a_stream_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bram_a_pkg.sv
// Shared defaults and FSM state encoding for the memory-A stream controller.
package bram_a_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFill  = 2'd1,
        StDrain = 2'd2
    } state_e;

endpackage

// File: rtl/bram_a_out_skid.sv
// Two-entry output FIFO that absorbs the one-cycle RAM read latency.
module bram_a_out_skid
    import bram_a_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_data_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_idx_q, wr_idx_d;
    logic              rd_idx_q, rd_idx_d;
    logic [1:0]        count_q, count_d;

    // Next-state: write at tail on push, advance head on pop; both may happen together.
    always_comb begin
        mem_d    = mem_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        if (push_i) begin
            mem_d[wr_idx_q] = push_data_i;
            wr_idx_d        = ~wr_idx_q;
        end
        if (pop_i) begin
            rd_idx_d = ~rd_idx_q;
        end
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    // State registers; storage is cleared so the head reads 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_idx_q <= 1'b0;
            rd_idx_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            count_q  <= count_d;
        end
    end

    assign head_data_o = mem_q[rd_idx_q];
    assign count_o     = count_q;

endmodule

// File: rtl/bram_a_stream_ctrl.sv
// Fill memory A from an input stream, then drain it in address order to an output stream.
module bram_a_stream_ctrl
    import bram_a_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              ena_A,
    output logic              wea_A,
    output logic [ADDR_W-1:0] addra_A,
    output logic [DATA_W-1:0] dina_A,
    input  logic [DATA_W-1:0] douta_A
);

    // Pointers carry one extra bit so DEPTH == 2**ADDR_W compares without wrapping.
    localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] DepthW  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] PtrOne  = (ADDR_W + 1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   out_cnt_q, out_cnt_d;
    logic              rd_inflight_q, rd_inflight_d;
    logic              done_q, done_d;

    logic [1:0]        fifo_count;
    logic [DATA_W-1:0] fifo_head;
    logic              pop;
    logic              rd_issue;
    logic [2:0]        occ;

    bram_a_out_skid #(
        .DATA_W (DATA_W)
    ) u_out_skid (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (rd_inflight_q),
        .push_data_i (douta_A),
        .pop_i       (pop),
        .head_data_o (fifo_head),
        .count_o     (fifo_count)
    );

    assign m_valid = (fifo_count != 2'd0);
    assign m_data  = fifo_head;
    assign pop     = m_valid && m_ready;
    // Buffered words plus the read whose data arrives next cycle.
    assign occ     = {1'b0, fifo_count} + {2'b00, rd_inflight_q};

    // FSM next-state, pointer updates and RAM port drive.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        out_cnt_d     = out_cnt_q;
        rd_inflight_d = 1'b0;
        done_d        = 1'b0;
        rd_issue      = 1'b0;
        s_ready       = 1'b0;
        ena_A         = 1'b0;
        wea_A         = 1'b0;
        addra_A       = '0;
        dina_A        = '0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StFill;
                    wr_ptr_d  = '0;
                    rd_ptr_d  = '0;
                    out_cnt_d = '0;
                end
            end
            StFill: begin
                s_ready = 1'b1;
                ena_A   = s_valid;
                wea_A   = s_valid;
                addra_A = wr_ptr_q[ADDR_W-1:0];
                dina_A  = s_data;
                if (s_valid) begin
                    wr_ptr_d = wr_ptr_q + PtrOne;
                    if (wr_ptr_q == LastIdx) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // A same-cycle pop frees a slot, which keeps 1 word/cycle under m_ready=1.
                rd_issue = (rd_ptr_q < DepthW) &&
                           ((occ < 3'd2) || (pop && (occ < 3'd3)));
                if (rd_issue) begin
                    ena_A         = 1'b1;
                    addra_A       = rd_ptr_q[ADDR_W-1:0];
                    rd_ptr_d      = rd_ptr_q + PtrOne;
                    rd_inflight_d = 1'b1;
                end
                if (pop) begin
                    out_cnt_d = out_cnt_q + PtrOne;
                    if (out_cnt_q == LastIdx) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            out_cnt_q     <= '0;
            rd_inflight_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            out_cnt_q     <= out_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            done_q        <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule
